// File: rtl/vga_pkg.sv
// Shared VGA defaults (640x480@60), a counter-width helper and a sprite descriptor.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_PULSE  = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_PULSE  = 2;
    localparam int unsigned DEF_V_BACK   = 33;

    // Widest geometry/colour any instance supports (X_W, Y_W <= 16, COLOR_BITS <= 8).
    localparam int unsigned SPR_GEOM_W  = 16;
    localparam int unsigned SPR_COLOR_W = 24;

    // Bits needed to count 0..count-1; never less than one.
    function automatic int unsigned width_for(input int unsigned count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    // Full-width sprite descriptor for register-map and software-facing blocks.
    typedef struct packed {
        logic [SPR_GEOM_W-1:0]  x;
        logic [SPR_GEOM_W-1:0]  y;
        logic [SPR_GEOM_W-1:0]  w;
        logic [SPR_GEOM_W-1:0]  h;
        logic [SPR_COLOR_W-1:0] color;
        logic                   en;
    } sprite_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus raw (unregistered) active, sync-window and end-of-frame flags.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_PULSE  = DEF_H_PULSE,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_PULSE  = DEF_V_PULSE,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           active_o,
    output logic           hsync_o,   // high inside the pulse window; polarity applied downstream
    output logic           vsync_o,
    output logic           eof_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    // Window bounds carry one spare bit so a pulse ending exactly at the total does not wrap.
    localparam logic [X_W:0] X_ACT_END = (X_W + 1)'(H_ACTIVE);
    localparam logic [X_W:0] HS_START  = (X_W + 1)'(H_ACTIVE + H_FRONT);
    localparam logic [X_W:0] HS_END    = (X_W + 1)'(H_ACTIVE + H_FRONT + H_PULSE);
    localparam logic [Y_W:0] Y_ACT_END = (Y_W + 1)'(V_ACTIVE);
    localparam logic [Y_W:0] VS_START  = (Y_W + 1)'(V_ACTIVE + V_FRONT);
    localparam logic [Y_W:0] VS_END    = (Y_W + 1)'(V_ACTIVE + V_FRONT + V_PULSE);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_last, y_last;
    logic [X_W:0]   x_ext;
    logic [Y_W:0]   y_ext;

    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);

    // Next raster position: x wraps every line, y advances on x wrap and wraps per frame.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_last) begin
            x_d = '0;
            y_d = y_last ? '0 : y_q + 1'b1;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_ext    = {1'b0, x_q};
    assign y_ext    = {1'b0, y_q};
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign active_o = (x_ext < X_ACT_END) && (y_ext < Y_ACT_END);
    assign hsync_o  = (x_ext >= HS_START) && (x_ext < HS_END);
    assign vsync_o  = (y_ext >= VS_START) && (y_ext < VS_END);
    assign eof_o    = x_last && y_last;

endmodule

// File: rtl/vga_sprite_renderer.sv
// VGA timing plus NUM_SPRITES priority rectangles with frame-synchronous shadow updates.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int unsigned             H_ACTIVE         = DEF_H_ACTIVE,
    parameter int unsigned             H_FRONT          = DEF_H_FRONT,
    parameter int unsigned             H_PULSE          = DEF_H_PULSE,
    parameter int unsigned             H_BACK           = DEF_H_BACK,
    parameter int unsigned             V_ACTIVE         = DEF_V_ACTIVE,
    parameter int unsigned             V_FRONT          = DEF_V_FRONT,
    parameter int unsigned             V_PULSE          = DEF_V_PULSE,
    parameter int unsigned             V_BACK           = DEF_V_BACK,
    parameter bit                      HSYNC_ACTIVE_LOW = 1'b1,
    parameter bit                      VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned             NUM_SPRITES      = 4,
    parameter int unsigned             COLOR_BITS       = 1,
    parameter logic [3*COLOR_BITS-1:0] BG_COLOR         = '0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK,
    localparam int unsigned X_W     = width_for(H_TOTAL),
    localparam int unsigned Y_W     = width_for(V_TOTAL),
    localparam int unsigned C_W     = 3 * COLOR_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SPRITES*X_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*Y_W-1:0] sprite_y,
    input  logic [NUM_SPRITES*X_W-1:0] sprite_w,
    input  logic [NUM_SPRITES*Y_W-1:0] sprite_h,
    input  logic [NUM_SPRITES*C_W-1:0] sprite_color,
    input  logic [NUM_SPRITES-1:0]     sprite_en,
    input  logic                       cfg_commit,
    output logic                       cfg_pending,
    output logic                       frame_start,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic [COLOR_BITS-1:0]      vga_r,
    output logic [COLOR_BITS-1:0]      vga_g,
    output logic [COLOR_BITS-1:0]      vga_b
);

    // Stage 0: raster counters and raw flags.
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           active, hs_raw, vs_raw, eof;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_PULSE  (H_PULSE),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_PULSE  (V_PULSE),
        .V_BACK   (V_BACK),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_timing (
        .clk_i    (clk),
        .rst_i    (rst),
        .x_o      (x),
        .y_o      (y),
        .active_o (active),
        .hsync_o  (hs_raw),
        .vsync_o  (vs_raw),
        .eof_o    (eof)
    );

    // Shadow sprite state, only ever reloaded on the end-of-frame edge.
    logic [X_W-1:0]         sx_q [NUM_SPRITES];
    logic [Y_W-1:0]         sy_q [NUM_SPRITES];
    logic [X_W-1:0]         sw_q [NUM_SPRITES];
    logic [Y_W-1:0]         sh_q [NUM_SPRITES];
    logic [C_W-1:0]         col_q[NUM_SPRITES];
    logic [NUM_SPRITES-1:0] en_q;
    logic                   pending_q, pending_d;
    logic                   load;

    // A commit landing on the eof cycle itself loads immediately.
    assign load = eof && (pending_q || cfg_commit);

    // Commit request latch: set by cfg_commit, cleared when the shadow load happens.
    always_comb begin
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b0;
        end else if (cfg_commit) begin
            pending_d = 1'b1;
        end
    end

    // Pending flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Shadow register bank: cleared by reset, copied from the inputs on a committed eof.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                sx_q[i]  <= '0;
                sy_q[i]  <= '0;
                sw_q[i]  <= '0;
                sh_q[i]  <= '0;
                col_q[i] <= '0;
            end
            en_q <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                sx_q[i]  <= sprite_x[i*X_W +: X_W];
                sy_q[i]  <= sprite_y[i*Y_W +: Y_W];
                sw_q[i]  <= sprite_w[i*X_W +: X_W];
                sh_q[i]  <= sprite_h[i*Y_W +: Y_W];
                col_q[i] <= sprite_color[i*C_W +: C_W];
            end
            en_q <= sprite_en;
        end
    end

    // Per-sprite hit test; right/bottom edges use one extra bit so large sprites clip, not wrap.
    logic [NUM_SPRITES-1:0] hit_d, hit_q;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [X_W:0] x_end;
        logic [Y_W:0] y_end;
        assign x_end    = {1'b0, sx_q[g]} + {1'b0, sw_q[g]};
        assign y_end    = {1'b0, sy_q[g]} + {1'b0, sh_q[g]};
        assign hit_d[g] = en_q[g] && (x >= sx_q[g]) && ({1'b0, x} < x_end)
                                  && (y >= sy_q[g]) && ({1'b0, y} < y_end);
    end

    logic valid1_q, active1_q, hs1_q, vs1_q, first1_q;

    // Stage 1: register hit flags with the raster flags that travel alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q  <= 1'b0;
            hit_q     <= '0;
            active1_q <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            first1_q  <= 1'b0;
        end else begin
            valid1_q  <= 1'b1;
            hit_q     <= hit_d;
            active1_q <= active;
            hs1_q     <= hs_raw;
            vs1_q     <= vs_raw;
            first1_q  <= (x == '0) && (y == '0);
        end
    end

    logic [C_W-1:0] color_q, color_d;
    logic           hsync_q, vsync_q, frame_start_q;

    // Priority mux: walk from the highest index down so the lowest-index hit wins.
    always_comb begin
        color_d = BG_COLOR;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                color_d = col_q[i];
            end
        end
        if (!(valid1_q && active1_q)) begin
            color_d = '0;
        end
    end

    // Stage 2: output registers; sync polarity applied here.
    always_ff @(posedge clk) begin
        if (rst) begin
            color_q       <= '0;
            hsync_q       <= HSYNC_ACTIVE_LOW;
            vsync_q       <= VSYNC_ACTIVE_LOW;
            frame_start_q <= 1'b0;
        end else begin
            color_q       <= color_d;
            hsync_q       <= hs1_q ^ HSYNC_ACTIVE_LOW;
            vsync_q       <= vs1_q ^ VSYNC_ACTIVE_LOW;
            frame_start_q <= valid1_q && first1_q;
        end
    end

    assign cfg_pending = pending_q;
    assign frame_start = frame_start_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_r       = color_q[C_W-1 -: COLOR_BITS];
    assign vga_g       = color_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign vga_b       = color_q[COLOR_BITS-1:0];

endmodule

// File: doc/vga_sprite_renderer.md
Name: vga_sprite_renderer

Overview:
- Parametrised VGA timing generator and rectangle renderer; successor to the fixed 640x480, 3-object, 1-bit-colour graphics driver.
- Draws NUM_SPRITES axis-aligned rectangles, each with its own position, size, enable and RGB colour.
- Priority: lowest index wins. Colour depth is configurable.
- Sprite state lives in shadow registers that load only at frame end, after a commit handshake, so no frame ever tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_PULSE, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vsync pulse (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_ACTIVE_LOW, 1, 1 = hsync pulse drives 0
- VSYNC_ACTIVE_LOW, 1, 1 = vsync pulse drives 0
- NUM_SPRITES, 4, number of rectangles (1..16)
- COLOR_BITS, 1, bits per colour channel
- BG_COLOR, 0, background {r,g,b} value, 3*COLOR_BITS wide
- Derived: H_TOTAL, V_TOTAL, X_W = $clog2(H_TOTAL), Y_W = $clog2(V_TOTAL), C_W = 3*COLOR_BITS

Ports:
- clk  in  1  pixel clock (~25.175 MHz for the defaults)
- rst  in  1  synchronous, active-high reset
- sprite_x  in  NUM_SPRITES*X_W  left edge of each sprite; sprite i occupies slice [i*X_W +: X_W]
- sprite_y  in  NUM_SPRITES*Y_W  top edge of each sprite
- sprite_w  in  NUM_SPRITES*X_W  width in pixels; 0 = not drawn
- sprite_h  in  NUM_SPRITES*Y_W  height in lines; 0 = not drawn
- sprite_color  in  NUM_SPRITES*C_W  {r,g,b} colour per sprite
- sprite_en  in  NUM_SPRITES  per-sprite enable
- cfg_commit  in  1  one-cycle request to load all sprite_* inputs at the next frame end
- cfg_pending  out  1  high from commit until the shadow load completes
- frame_start  out  1  one-cycle pulse aligned with the first active pixel on the pins (x=0, y=0)
- vga_hsync  out  1  registered hsync
- vga_vsync  out  1  registered vsync
- vga_r, vga_g, vga_b  out  COLOR_BITS each  registered colour

Behaviour:
- Counters: x counts 0..H_TOTAL-1, then wraps to 0 and increments y. y counts 0..V_TOTAL-1, then wraps to 0.
- End of frame (eof) = cycle where x = H_TOTAL-1 and y = V_TOTAL-1.
- Sync timing: hsync is asserted for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_PULSE; vsync likewise on y. Asserted level follows the *_ACTIVE_LOW parameters.
- Pipeline stage 0: counters.
- Pipeline stage 1: per-sprite hit flags registered.
  - hit_i = en_i & (x >= sx_i) & (x < sx_i+w_i) & (y >= sy_i) & (y < sy_i+h_i).
  - Comparisons use X_W+1 / Y_W+1 bit sums so edges near the counter limit do not wrap.
  - Active, hsync and vsync are delayed alongside the hit flags.
- Pipeline stage 2: priority mux plus output registers.
  - Colour = colour of the lowest-index hit sprite when active, else BG_COLOR when active, else 0.
  - Total latency from counter to pins is 2 clocks; syncs and colour are mutually aligned.
- Blanking: colour outputs are 0 whenever outside the active area, regardless of sprites.
- Commit handshake:
  - A cfg_commit pulse sets cfg_pending.
  - On eof with cfg_pending=1, all shadow registers load from the sprite_* inputs and cfg_pending clears on the next cycle.
  - Commit on the eof cycle itself loads on that same edge; cfg_pending never rises.
  - Commit while already pending has no extra effect. The loaded values are those present on the eof cycle.
  - Sprite inputs must be held stable from commit until cfg_pending falls.
- Sprites crossing the right or bottom edge are clipped. Sprites placed fully in blanking are invisible.
- Reset values:
  - Counters = 0; shadow registers = 0 (all sprites disabled); cfg_pending = 0; frame_start = 0.
  - vga_hsync and vga_vsync drive their inactive levels (1 for active-low).
  - Colour outputs = 0; pipeline valid bits cleared.
- Reset mid-frame restarts at x=y=0 and drops any pending commit. The first pixel is valid 2 cycles after rst falls.

Decomposition:
- Package vga_pkg: timing localparams for the 640x480@60 defaults, a width helper function, and the sprite_t struct {x, y, w, h, color, en}.
- Sub-module vga_timing_gen: owns the counters and raw sync/active/eof generation; reusable by future display blocks.
- Hit compare and priority mux stay in the top module as generate loops.

Test Plan:
- Timing: default parameters, release reset. Then:
  - hsync low for exactly 96 clocks per 800-clock line.
  - vsync low for exactly 2 lines per 525-line frame.
  - frame_start has an 420,000-clock period.
- Single sprite: en0=1, x=100, y=50, w=8, h=4, colour=3'b101, then commit. On the next frame, pixels (100..107, 50..53) show 101 and pixel (108, 50) shows BG, with output 2 clocks after the counter.
- Priority: sprite0 at (10,10,4,4) colour 100 overlaps sprite1 at (12,12,4,4) colour 010. Pixel (12,12) shows 100; pixel (15,15) shows 010.
- Tear-free update: commit a new x mid-frame (y=200). Then:
  - The remaining lines of the current frame still show the old x.
  - cfg_pending stays high until eof.
  - The new x appears from frame_start onward.
- Edge cases:
  - Sprite at x=636, w=8 is clipped; columns 640..643 stay black.
  - w=0 draws nothing.
  - Commit on the exact eof cycle loads immediately, with cfg_pending staying 0.
- Reset mid-frame (rst at y=300) plus a pending commit: counters return to 0, the commit is dropped, and all outputs return to their reset values.
